// File: rtl/clean_log_walk_ctrl.sv
// Log-clean walker: invalidates ring entries older than a clean-up op number, then writes back the advanced head.
// Optional cumulative entry counter (port walk_stat_total) enabled by defining CLEAN_LOG_WALK_STATS_EN.
module clean_log_walk_ctrl #(
    parameter int LOG_IDX_W = 7,
    parameter int OP_NUM_W  = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_walk,
    input  logic [LOG_IDX_W-1:0] hdr_head_idx,
    input  logic [OP_NUM_W-1:0]  hdr_head_opnum,
    input  logic [OP_NUM_W-1:0]  clean_upto_opnum,
    output logic                 walk_done,
    output logic                 walk_ent_wr_req_val,
    output logic [LOG_IDX_W-1:0] walk_ent_wr_req_addr,
    input  logic                 ent_walk_wr_req_rdy,
    output logic                 walk_hdr_wr_req_val,
    output logic [LOG_IDX_W-1:0] walk_hdr_wr_head_idx,
    output logic [OP_NUM_W-1:0]  walk_hdr_wr_head_opnum,
    input  logic                 hdr_walk_wr_req_rdy,
`ifdef CLEAN_LOG_WALK_STATS_EN
    output logic [31:0]          walk_stat_total,
`endif
    output logic [LOG_IDX_W:0]   walk_last_cnt
);

    localparam int CNT_W = LOG_IDX_W + 1;
    localparam logic [OP_NUM_W-1:0] RING_DEPTH = OP_NUM_W'(1) << LOG_IDX_W;

    typedef enum logic [1:0] {
        READY,
        CLEAR_ENT,
        WR_HDR
    } state_t;

    state_t               state_reg, state_next;
    logic [LOG_IDX_W-1:0] idx_reg;
    logic [OP_NUM_W-1:0]  opnum_reg;
    logic [CNT_W-1:0]     rem_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic [CNT_W-1:0]     last_cnt_reg;

    logic [OP_NUM_W-1:0]  op_diff;
    logic [CNT_W-1:0]     start_rem;
    logic                 ent_hs;
    logic                 hdr_hs;

    // Entries to clean, clamped to one full lap of the ring.
    always_comb begin
        op_diff = clean_upto_opnum - hdr_head_opnum;
        if (clean_upto_opnum <= hdr_head_opnum) begin
            start_rem = '0;
        end else if (op_diff >= RING_DEPTH) begin
            start_rem = CNT_W'(1) << LOG_IDX_W;
        end else begin
            start_rem = op_diff[CNT_W-1:0];
        end
    end

    always_comb begin
        state_next             = state_reg;
        walk_done              = 1'b0;
        walk_ent_wr_req_val    = 1'b0;
        walk_hdr_wr_req_val    = 1'b0;
        walk_ent_wr_req_addr   = idx_reg;
        walk_hdr_wr_head_idx   = idx_reg;
        walk_hdr_wr_head_opnum = opnum_reg;
        ent_hs                 = 1'b0;
        hdr_hs                 = 1'b0;
        case (state_reg)
            READY: begin
                walk_done = 1'b1;
                if (start_walk && (start_rem != '0)) begin
                    state_next = CLEAR_ENT;
                end
            end
            CLEAR_ENT: begin
                // Reset kills the request in the same cycle, not one edge later.
                walk_ent_wr_req_val = !rst;
                ent_hs              = !rst && ent_walk_wr_req_rdy;
                if (ent_hs && (rem_reg == CNT_W'(1))) begin
                    state_next = WR_HDR;
                end
            end
            WR_HDR: begin
                walk_hdr_wr_req_val = !rst;
                hdr_hs              = !rst && hdr_walk_wr_req_rdy;
                if (hdr_hs) begin
                    state_next = READY;
                end
            end
            default: state_next = READY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= READY;
            idx_reg      <= '0;
            opnum_reg    <= '0;
            rem_reg      <= '0;
            cnt_reg      <= '0;
            last_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                READY: begin
                    if (start_walk) begin
                        idx_reg   <= hdr_head_idx;
                        opnum_reg <= hdr_head_opnum;
                        rem_reg   <= start_rem;
                        cnt_reg   <= '0;
                        if (start_rem == '0) begin
                            last_cnt_reg <= '0;
                        end
                    end
                end
                CLEAR_ENT: begin
                    if (ent_hs) begin
                        idx_reg   <= idx_reg + LOG_IDX_W'(1);
                        opnum_reg <= opnum_reg + OP_NUM_W'(1);
                        rem_reg   <= rem_reg - CNT_W'(1);
                        cnt_reg   <= cnt_reg + CNT_W'(1);
                    end
                end
                WR_HDR: begin
                    if (hdr_hs) begin
                        last_cnt_reg <= cnt_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    assign walk_last_cnt = last_cnt_reg;

`ifdef CLEAN_LOG_WALK_STATS_EN
    logic [31:0] stat_total_reg;

    // Counts every accepted invalidate, including those of walks later abandoned.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_total_reg <= '0;
        end else if (ent_hs && (stat_total_reg != 32'hFFFF_FFFF)) begin
            stat_total_reg <= stat_total_reg + 32'd1;
        end
    end

    assign walk_stat_total = stat_total_reg;
`endif

endmodule

// File: tb/tb_clean_log_walk_ctrl.sv
// Bench for clean_log_walk_ctrl: scoreboarded entry/header writes, latency, zero-length, back-pressure and mid-walk reset.
// Define CLEAN_LOG_WALK_STATS_EN to also check walk_stat_total.
module tb_clean_log_walk_ctrl;

    localparam int LOG_IDX_W = 7;
    localparam int OP_NUM_W  = 64;

    logic                 clk;
    logic                 rst;
    logic                 start_walk;
    logic [LOG_IDX_W-1:0] hdr_head_idx;
    logic [OP_NUM_W-1:0]  hdr_head_opnum;
    logic [OP_NUM_W-1:0]  clean_upto_opnum;
    logic                 walk_done;
    logic                 walk_ent_wr_req_val;
    logic [LOG_IDX_W-1:0] walk_ent_wr_req_addr;
    logic                 ent_walk_wr_req_rdy;
    logic                 walk_hdr_wr_req_val;
    logic [LOG_IDX_W-1:0] walk_hdr_wr_head_idx;
    logic [OP_NUM_W-1:0]  walk_hdr_wr_head_opnum;
    logic                 hdr_walk_wr_req_rdy;
    logic [LOG_IDX_W:0]   walk_last_cnt;
`ifdef CLEAN_LOG_WALK_STATS_EN
    logic [31:0]          walk_stat_total;
`endif

    int checks = 0;
    int errors = 0;
    int ent_hs_cnt = 0;
    int hdr_hs_cnt = 0;

    logic [LOG_IDX_W-1:0] exp_addr_q[$];
    logic [LOG_IDX_W-1:0] exp_hidx_q[$];
    logic [OP_NUM_W-1:0]  exp_hop_q[$];

    clean_log_walk_ctrl #(
        .LOG_IDX_W(LOG_IDX_W),
        .OP_NUM_W (OP_NUM_W)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .start_walk            (start_walk),
        .hdr_head_idx          (hdr_head_idx),
        .hdr_head_opnum        (hdr_head_opnum),
        .clean_upto_opnum      (clean_upto_opnum),
        .walk_done             (walk_done),
        .walk_ent_wr_req_val   (walk_ent_wr_req_val),
        .walk_ent_wr_req_addr  (walk_ent_wr_req_addr),
        .ent_walk_wr_req_rdy   (ent_walk_wr_req_rdy),
        .walk_hdr_wr_req_val   (walk_hdr_wr_req_val),
        .walk_hdr_wr_head_idx  (walk_hdr_wr_head_idx),
        .walk_hdr_wr_head_opnum(walk_hdr_wr_head_opnum),
        .hdr_walk_wr_req_rdy   (hdr_walk_wr_req_rdy),
`ifdef CLEAN_LOG_WALK_STATS_EN
        .walk_stat_total       (walk_stat_total),
`endif
        .walk_last_cnt         (walk_last_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every handshake seen one half-cycle before the accepting edge.
    logic                 prev_ent_stall = 1'b0;
    logic                 prev_hdr_stall = 1'b0;
    logic [LOG_IDX_W-1:0] prev_addr;
    logic [LOG_IDX_W-1:0] prev_hidx;
    logic [OP_NUM_W-1:0]  prev_hop;
    logic [LOG_IDX_W-1:0] exp_a;
    logic [OP_NUM_W-1:0]  exp_o;

    always @(negedge clk) begin
        if (!rst) begin
            if (walk_ent_wr_req_val && prev_ent_stall) begin
                checks++;
                if (walk_ent_wr_req_addr !== prev_addr) begin
                    errors++;
                    $display("FAIL ent_stable: addr=%0d required=%0d", walk_ent_wr_req_addr, prev_addr);
                end
            end
            if (walk_hdr_wr_req_val && prev_hdr_stall) begin
                checks++;
                if (walk_hdr_wr_head_idx !== prev_hidx || walk_hdr_wr_head_opnum !== prev_hop) begin
                    errors++;
                    $display("FAIL hdr_stable: idx=%0d op=%0d required idx=%0d op=%0d",
                             walk_hdr_wr_head_idx, walk_hdr_wr_head_opnum, prev_hidx, prev_hop);
                end
            end
            if (walk_ent_wr_req_val && ent_walk_wr_req_rdy) begin
                ent_hs_cnt++;
                checks++;
                if (exp_addr_q.size() == 0) begin
                    errors++;
                    $display("FAIL ent_extra: unexpected entry write addr=%0d", walk_ent_wr_req_addr);
                end else begin
                    exp_a = exp_addr_q.pop_front();
                    if (walk_ent_wr_req_addr !== exp_a) begin
                        errors++;
                        $display("FAIL ent_addr: addr=%0d required=%0d", walk_ent_wr_req_addr, exp_a);
                    end
                end
            end
            if (walk_hdr_wr_req_val && hdr_walk_wr_req_rdy) begin
                hdr_hs_cnt++;
                checks++;
                if (exp_hidx_q.size() == 0) begin
                    errors++;
                    $display("FAIL hdr_extra: unexpected header write idx=%0d", walk_hdr_wr_head_idx);
                end else begin
                    exp_a = exp_hidx_q.pop_front();
                    exp_o = exp_hop_q.pop_front();
                    if (walk_hdr_wr_head_idx !== exp_a || walk_hdr_wr_head_opnum !== exp_o) begin
                        errors++;
                        $display("FAIL hdr_write: idx=%0d op=%0d required idx=%0d op=%0d",
                                 walk_hdr_wr_head_idx, walk_hdr_wr_head_opnum, exp_a, exp_o);
                    end
                end
            end
        end
        prev_ent_stall = !rst && walk_ent_wr_req_val && !ent_walk_wr_req_rdy;
        prev_hdr_stall = !rst && walk_hdr_wr_req_val && !hdr_walk_wr_req_rdy;
        prev_addr      = walk_ent_wr_req_addr;
        prev_hidx      = walk_hdr_wr_head_idx;
        prev_hop       = walk_hdr_wr_head_opnum;
    end

    // Pulses start for one edge and pushes the expected walk; returns at start edge + 1.
    task automatic do_start(input logic [LOG_IDX_W-1:0] idx, input logic [OP_NUM_W-1:0] op,
                            input logic [OP_NUM_W-1:0] upto, output int n);
        logic [OP_NUM_W-1:0]  d;
        logic [LOG_IDX_W-1:0] a;
        @(posedge clk);
        #1;
        hdr_head_idx     = idx;
        hdr_head_opnum   = op;
        clean_upto_opnum = upto;
        start_walk       = 1'b1;
        if (upto <= op) begin
            n = 0;
        end else begin
            d = upto - op;
            n = (d > 64'd128) ? 128 : int'(d);
        end
        a = idx;
        for (int i = 0; i < n; i++) begin
            exp_addr_q.push_back(a);
            a = a + 7'd1;
        end
        if (n > 0) begin
            exp_hidx_q.push_back(a);
            exp_hop_q.push_back(op + 64'(n));
        end
        @(posedge clk);
        #1;
        start_walk = 1'b0;
    endtask

    // Counts cycles after the start edge until walk_done is seen (bounded).
    task automatic wait_idle(output int cyc);
        cyc = 1;
        @(negedge clk);
        while (!walk_done && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (walk_ent_wr_req_val !== 1'b0 || walk_hdr_wr_req_val !== 1'b0) begin
                errors++;
                $display("FAIL reset_valids: ent=%b hdr=%b required 0 0", walk_ent_wr_req_val, walk_hdr_wr_req_val);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (walk_done !== 1'b1 || walk_last_cnt !== '0) begin
            errors++;
            $display("FAIL reset_state: done=%b last_cnt=%0d required 1 0", walk_done, walk_last_cnt);
        end
`ifdef CLEAN_LOG_WALK_STATS_EN
        checks++;
        if (walk_stat_total !== 32'd0) begin
            errors++;
            $display("FAIL reset_stats: total=%0d required 0", walk_stat_total);
        end
`endif
    endtask

    task automatic test_basic_walk(input logic [LOG_IDX_W-1:0] idx, input logic [OP_NUM_W-1:0] op,
                                   input logic [OP_NUM_W-1:0] upto, input string name);
        int n;
        int cyc;
        ent_walk_wr_req_rdy = 1'b1;
        hdr_walk_wr_req_rdy = 1'b1;
        do_start(idx, op, upto, n);
        wait_idle(cyc);
        checks++;
        if (cyc !== n + 2) begin
            errors++;
            $display("FAIL %s_latency: done after %0d cycles required %0d", name, cyc, n + 2);
        end
        checks++;
        if (walk_last_cnt !== 8'(n)) begin
            errors++;
            $display("FAIL %s_last_cnt: %0d required %0d", name, walk_last_cnt, n);
        end
        checks++;
        if (exp_addr_q.size() != 0 || exp_hidx_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drained: %0d entry and %0d header writes missing", name,
                     exp_addr_q.size(), exp_hidx_q.size());
        end
    endtask

    task automatic test_zero_walk(input logic [OP_NUM_W-1:0] upto, input string name);
        int n;
        int ent0;
        int hdr0;
        ent0 = ent_hs_cnt;
        hdr0 = hdr_hs_cnt;
        do_start(7'd3, 64'd100, upto, n);
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (walk_done !== 1'b1 || walk_ent_wr_req_val !== 1'b0 || walk_hdr_wr_req_val !== 1'b0) begin
                errors++;
                $display("FAIL %s_idle: done=%b ent=%b hdr=%b required 1 0 0", name,
                         walk_done, walk_ent_wr_req_val, walk_hdr_wr_req_val);
            end
        end
        checks++;
        if (walk_last_cnt !== '0 || ent_hs_cnt != ent0 || hdr_hs_cnt != hdr0) begin
            errors++;
            $display("FAIL %s_result: last_cnt=%0d writes=%0d/%0d required 0 0/0", name,
                     walk_last_cnt, ent_hs_cnt - ent0, hdr_hs_cnt - hdr0);
        end
    endtask

    task automatic test_back_pressure();
        int n;
        int k;
        int hdr_low;
        int ent0;
        int hdr0;
        int pat[4] = '{1, 0, 0, 1};
        ent0 = ent_hs_cnt;
        hdr0 = hdr_hs_cnt;
        hdr_low = 0;
        k = 0;
        do_start(7'd60, 64'd500, 64'd505, n);
        forever begin
            ent_walk_wr_req_rdy = pat[k % 4][0];
            if (walk_hdr_wr_req_val && hdr_low < 3) begin
                hdr_walk_wr_req_rdy = 1'b0;
                hdr_low++;
            end else begin
                hdr_walk_wr_req_rdy = 1'b1;
            end
            start_walk       = (k == 2 || k == 5);
            hdr_head_idx     = 7'd10;
            hdr_head_opnum   = 64'd0;
            clean_upto_opnum = 64'd50;
            @(negedge clk);
            if (walk_done || k >= 200) break;
            @(posedge clk);
            #1;
            k++;
        end
        start_walk          = 1'b0;
        ent_walk_wr_req_rdy = 1'b1;
        hdr_walk_wr_req_rdy = 1'b1;
        checks++;
        if (!walk_done || hdr_low != 3) begin
            errors++;
            $display("FAIL bp_finish: done=%b hdr_stall_cycles=%0d required 1 3", walk_done, hdr_low);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (walk_last_cnt !== 8'd5 || ent_hs_cnt - ent0 != 5 || hdr_hs_cnt - hdr0 != 1 || !walk_done) begin
            errors++;
            $display("FAIL bp_result: last_cnt=%0d ent=%0d hdr=%0d done=%b required 5 5 1 1",
                     walk_last_cnt, ent_hs_cnt - ent0, hdr_hs_cnt - hdr0, walk_done);
        end
    endtask

    task automatic test_mid_reset();
        int n;
        int ent0;
        int hdr0;
        ent0 = ent_hs_cnt;
        hdr0 = hdr_hs_cnt;
        ent_walk_wr_req_rdy = 1'b1;
        hdr_walk_wr_req_rdy = 1'b1;
        do_start(7'd40, 64'd1000, 64'd1010, n);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (walk_ent_wr_req_val !== 1'b0 || walk_hdr_wr_req_val !== 1'b0) begin
            errors++;
            $display("FAIL midrst_valids: ent=%b hdr=%b required 0 0", walk_ent_wr_req_val, walk_hdr_wr_req_val);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_addr_q.delete();
        exp_hidx_q.delete();
        exp_hop_q.delete();
        @(negedge clk);
        checks++;
        if (walk_done !== 1'b1 || walk_ent_wr_req_val !== 1'b0) begin
            errors++;
            $display("FAIL midrst_ready: done=%b ent=%b required 1 0", walk_done, walk_ent_wr_req_val);
        end
`ifdef CLEAN_LOG_WALK_STATS_EN
        checks++;
        if (walk_stat_total !== 32'd0) begin
            errors++;
            $display("FAIL midrst_stats: total=%0d required 0", walk_stat_total);
        end
`endif
        repeat (4) @(negedge clk);
        checks++;
        if (ent_hs_cnt - ent0 != 1 || hdr_hs_cnt != hdr0) begin
            errors++;
            $display("FAIL midrst_traffic: ent=%0d hdr=%0d required 1 0", ent_hs_cnt - ent0, hdr_hs_cnt - hdr0);
        end
        test_basic_walk(7'd100, 64'd7, 64'd14, "post_rst");
`ifdef CLEAN_LOG_WALK_STATS_EN
        checks++;
        if (walk_stat_total !== 32'd7) begin
            errors++;
            $display("FAIL stats_total: total=%0d required 7", walk_stat_total);
        end
`endif
    endtask

    initial begin
        rst                 = 1'b1;
        start_walk          = 1'b0;
        hdr_head_idx        = '0;
        hdr_head_opnum      = '0;
        clean_upto_opnum    = '0;
        ent_walk_wr_req_rdy = 1'b0;
        hdr_walk_wr_req_rdy = 1'b0;
        test_reset();
        test_basic_walk(7'd5, 64'd100, 64'd104, "basic");
        test_zero_walk(64'd100, "zero_eq");
        test_basic_walk(7'd126, 64'd10, 64'd13, "wrap");
        test_zero_walk(64'd50, "zero_lt");
        test_basic_walk(7'd20, 64'd0, 64'd1000, "full_ring");
        test_back_pressure();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
